alu_muldiv_seq: RTL

- Parametrised multi-cycle arithmetic unit alongside the single-cycle ALU in the execute stage.
- Implements the RV32M multiply/divide group: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Valid/ready handshakes on both sides let the pipeline stall on it; a flush input kills in-flight work.

---
 rtl/alu_muldiv_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring
// divider, one bit per cycle, with valid/ready handshakes and flush.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic             neg_q, rneg_q, fast_q;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo, opnd;
  logic [CW-1:0]    count;

  logic             sa, sb, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, fast_val;

  logic [WIDTH:0]     sum, rem_sh, diff, nxt_hi;
  logic [WIDTH-1:0]   nxt_lo, quo, rem, final_res;
  logic [2*WIDTH-1:0] prod, sprod;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand decode at acceptance: signs, magnitudes and the divide fast path.
  always_comb begin
    sa       = (op == 3'b000 || op == 3'b001 || op == 3'b010 ||
                op == 3'b100 || op == 3'b110) && a[WIDTH-1];
    sb       = (op == 3'b000 || op == 3'b001 || op == 3'b100 ||
                op == 3'b110) && b[WIDTH-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    div_zero = op[2] && (b == '0);
    ovf      = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    fast_val = '0;
    if (div_zero)
      fast_val = op[1] ? a : '1;
    else if (ovf)
      fast_val = op[1] ? '0 : a;
  end

  // One iteration of either datapath, plus sign fix-up of the final value.
  always_comb begin
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    nxt_hi = hi;
    nxt_lo = lo;
    if (!op_q[2]) begin
      sum    = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], lo[WIDTH-1:1]};
    end else begin
      rem_sh = {hi[WIDTH-1:0], lo[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd};
      if (!diff[WIDTH]) begin
        nxt_hi = diff;
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh;
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end
    prod  = {nxt_hi[WIDTH-1:0], nxt_lo};
    sprod = neg_q ? -prod : prod;
    quo   = neg_q ? -nxt_lo : nxt_lo;
    rem   = rneg_q ? -nxt_hi[WIDTH-1:0] : nxt_hi[WIDTH-1:0];
    if (op_q[2])
      final_res = op_q[1] ? rem : quo;
    else
      final_res = (op_q[1:0] == 2'b00) ? sprod[WIDTH-1:0] : sprod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      fast_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      count  <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= op;
          neg_q  <= sa ^ sb;
          rneg_q <= sa;
          fast_q <= div_zero | ovf;
          count  <= CW'(WIDTH);
          hi     <= '0;
          if (div_zero | ovf) result <= fast_val;
          if (op[2]) begin
            lo   <= a_mag;
            opnd <= b_mag;
          end else begin
            lo   <= b_mag;
            opnd <= a_mag;
          end
          state <= BUSY;
        end
        // Fast-path results were written at acceptance; just present them.
        BUSY: if (fast_q) begin
          state <= DONE;
        end else begin
          hi    <= nxt_hi;
          lo    <= nxt_lo;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result <= final_res;
            state  <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
